// File: rtl/gfx_pkg.sv
// Shared types and constants for the G10k command queue.
//   GFX_CMD_W/GFX_OP_W/GFX_DATA_W : command field widths
//   gfx_cmd_t                     : {opcode, data} command payload
//   gfx_state_e                   : issue FSM encoding
package gfx_pkg;

  localparam int unsigned GFX_CMD_W  = 24;
  localparam int unsigned GFX_OP_W   = 8;
  localparam int unsigned GFX_DATA_W = 16;

  typedef struct packed {
    logic [GFX_OP_W-1:0]   opcode;
    logic [GFX_DATA_W-1:0] data;
  } gfx_cmd_t;

  typedef enum logic {
    GFX_ST_IDLE = 1'b0,
    GFX_ST_GAP  = 1'b1
  } gfx_state_e;

endpackage

// File: rtl/gfx_cmd_queue_if.sv
// Connector/G10k side bundle of the command queue.
//   in_cmd, in_start      : command write from the bus connector
//   drain_en, ovf_clr     : drain window and sticky overflow clear
//   out_cmd, out_start    : command issue to G10k
//   level, full, empty,
//   overflow, irq_drained : queue status
// master drives commands/controls, slave is the queue.
interface gfx_cmd_queue_if #(
  parameter int unsigned AW = 4
);
  import gfx_pkg::*;

  gfx_cmd_t    in_cmd;
  logic        in_start;
  logic        drain_en;
  logic        ovf_clr;
  gfx_cmd_t    out_cmd;
  logic        out_start;
  logic [AW:0] level;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        irq_drained;

  modport master (
    output in_cmd, in_start, drain_en, ovf_clr,
    input  out_cmd, out_start, level, full, empty, overflow, irq_drained
  );

  modport slave (
    input  in_cmd, in_start, drain_en, ovf_clr,
    output out_cmd, out_start, level, full, empty, overflow, irq_drained
  );

endinterface

// File: rtl/gfx_cmd_fifo_mem.sv
// DEPTH x command register array, one write port, asynchronous read.
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational)
module gfx_cmd_fifo_mem
  import gfx_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  gfx_cmd_t      wdata_i,
  input  logic [AW-1:0] raddr_i,
  output gfx_cmd_t      rdata_o
);

  gfx_cmd_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/gfx_cmd_queue.sv
// Command FIFO between the bus connector and G10k. Commands are stored as
// strobed and replayed one pulse at a time while drain_en is high, with
// ISSUE_GAP idle cycles after each issue.
//   clk, rst : clock, synchronous active-high reset
//   bus      : gfx_cmd_queue_if slave (write, issue and status signals)
module gfx_cmd_queue
  import gfx_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AW        = 4,
  parameter int unsigned ISSUE_GAP = 2
) (
  input logic             clk,
  input logic             rst,
  gfx_cmd_queue_if.slave  bus
);

  localparam int unsigned LW       = AW + 1;
  localparam int unsigned GW       = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam int unsigned GAP_INIT = (ISSUE_GAP > 0) ? ISSUE_GAP - 1 : 0;

  gfx_state_e    state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          full_q, empty_q;
  gfx_cmd_t      out_cmd_q, out_cmd_d;
  logic          out_start_q, out_start_d;
  logic          irq_q, irq_d;

  gfx_cmd_t      rd_data;
  logic          is_full, is_empty;
  logic          issue, wr_acc, wr_drop;

  gfx_cmd_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wptr_q),
    .wdata_i (bus.in_cmd),
    .raddr_i (rptr_q),
    .rdata_o (rd_data)
  );

  // Write acceptance, occupancy and sticky overflow.
  // A write into a full queue is still taken when an issue frees a slot in the same cycle.
  always_comb begin
    is_full    = (level_q == LW'(DEPTH));
    is_empty   = (level_q == '0);
    issue      = (state_q == GFX_ST_IDLE) && !is_empty && bus.drain_en;
    wr_acc     = bus.in_start && (!is_full || issue);
    wr_drop    = bus.in_start && is_full && !issue;
    wptr_d     = wr_acc ? wptr_q + 1'b1 : wptr_q;
    level_d    = level_q + LW'(wr_acc) - LW'(issue);
    overflow_d = overflow_q;
    if (wr_drop) begin
      overflow_d = 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_d = 1'b0;
    end
    irq_d      = issue && (level_q == LW'(1)) && !wr_acc;
  end

  // Issue FSM: next state and registered issue outputs.
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    rptr_d      = rptr_q;
    out_start_d = 1'b0;
    out_cmd_d   = '0;
    case (state_q)
      GFX_ST_IDLE: begin
        if (issue) begin
          out_start_d = 1'b1;
          out_cmd_d   = rd_data;
          rptr_d      = rptr_q + 1'b1;
          if (ISSUE_GAP > 0) begin
            state_d = GFX_ST_GAP;
            gap_d   = GW'(GAP_INIT);
          end
        end
      end
      GFX_ST_GAP: begin
        // Gap runs to completion even if the drain window closes.
        if (gap_q == '0) begin
          state_d = GFX_ST_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = GFX_ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= GFX_ST_IDLE;
      gap_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      out_cmd_q   <= '0;
      out_start_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      full_q      <= (level_d == LW'(DEPTH));
      empty_q     <= (level_d == '0);
      out_cmd_q   <= out_cmd_d;
      out_start_q <= out_start_d;
      irq_q       <= irq_d;
    end
  end

  assign bus.out_cmd     = out_cmd_q;
  assign bus.out_start   = out_start_q;
  assign bus.level       = level_q;
  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.overflow    = overflow_q;
  assign bus.irq_drained = irq_q;

endmodule

// File: tb/tb_gfx_cmd_queue.sv
// Bench for gfx_cmd_queue: u_dut uses ISSUE_GAP=2, u_dut0 uses ISSUE_GAP=0.
// Writes push expected commands into per-DUT queues; a negedge monitor pops
// and compares whenever out_start is seen.
module tb_gfx_cmd_queue;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   cyc;

  logic [23:0] exp0 [$];
  logic [23:0] exp1 [$];
  int          pulses0 [$];
  int          pulses1 [$];

  gfx_cmd_queue_if #(.AW(4)) bus  ();
  gfx_cmd_queue_if #(.AW(4)) bus0 ();

  gfx_cmd_queue #(.DEPTH(16), .AW(4), .ISSUE_GAP(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  gfx_cmd_queue #(.DEPTH(16), .AW(4), .ISSUE_GAP(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard for both DUTs.
  always @(negedge clk) begin : mon
    logic [23:0] e;
    cyc++;
    if (!rst) begin
      if (bus.out_start) begin
        pulses0.push_back(cyc);
        if (exp0.size() == 0) begin
          chk("spurious_issue_gap2", 32'(bus.out_cmd), 32'hDEAD_BEEF);
        end else begin
          e = exp0.pop_front();
          chk("out_cmd_gap2", 32'(bus.out_cmd), 32'(e));
          chk("irq_on_issue_gap2", 32'(bus.irq_drained), 32'(exp0.size() == 0));
        end
      end else begin
        chk("idle_out_cmd_gap2", 32'(bus.out_cmd), 32'h0);
        chk("irq_without_issue_gap2", 32'(bus.irq_drained), 32'h0);
      end
      if (bus0.out_start) begin
        pulses1.push_back(cyc);
        if (exp1.size() == 0) begin
          chk("spurious_issue_gap0", 32'(bus0.out_cmd), 32'hDEAD_BEEF);
        end else begin
          e = exp1.pop_front();
          chk("out_cmd_gap0", 32'(bus0.out_cmd), 32'(e));
          chk("irq_on_issue_gap0", 32'(bus0.irq_drained), 32'(exp1.size() == 0));
        end
      end else begin
        chk("idle_out_cmd_gap0", 32'(bus0.out_cmd), 32'h0);
        chk("irq_without_issue_gap0", 32'(bus0.irq_drained), 32'h0);
      end
    end
  end

  // Advance to the drive point just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One write strobe; the expectation is pushed once the edge has sampled it.
  task automatic wr(input int sel, input logic [23:0] cmd, input bit accept);
    if (sel == 0) begin
      bus.in_cmd   = cmd;
      bus.in_start = 1'b1;
    end else begin
      bus0.in_cmd   = cmd;
      bus0.in_start = 1'b1;
    end
    @(posedge clk);
    if (accept) begin
      if (sel == 0) exp0.push_back(cmd);
      else          exp1.push_back(cmd);
    end
    #2;
    bus.in_start  = 1'b0;
    bus.in_cmd    = '0;
    bus0.in_start = 1'b0;
    bus0.in_cmd   = '0;
  endtask

  task automatic wait_pulses(input int sel, input int n, input int budget, input string name);
    int k;
    k = 0;
    while (((sel == 0) ? pulses0.size() : pulses1.size()) < n && k < budget) begin
      tick();
      k++;
    end
    chk(name, 32'((sel == 0) ? pulses0.size() : pulses1.size()), 32'(n));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    rst   = 1'b1;
    bus.in_cmd    = '0;
    bus.in_start  = 1'b0;
    bus.drain_en  = 1'b0;
    bus.ovf_clr   = 1'b0;
    bus0.in_cmd   = '0;
    bus0.in_start = 1'b0;
    bus0.drain_en = 1'b0;
    bus0.ovf_clr  = 1'b0;

    // Reset then idle
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_cmd", 32'(bus.out_cmd), 32'h0);
    chk("rst_out_start", 32'(bus.out_start), 32'h0);
    chk("rst_level", 32'(bus.level), 32'h0);
    chk("rst_full", 32'(bus.full), 32'h0);
    chk("rst_empty", 32'(bus.empty), 32'h1);
    chk("rst_overflow", 32'(bus.overflow), 32'h0);
    chk("rst_irq", 32'(bus.irq_drained), 32'h0);
    chk("rst_level_gap0", 32'(bus0.level), 32'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_empty", 32'(bus.empty), 32'h1);
      chk("idle_level", 32'(bus.level), 32'h0);
      chk("idle_out_start", 32'(bus.out_start), 32'h0);
    end

    // Ordered drain with gap
    wr(0, 24'h030000, 1'b1);
    wr(0, 24'h040D0D, 1'b1);
    wr(0, 24'h051211, 1'b1);
    chk("ord_level3", 32'(bus.level), 32'h3);
    pulses0.delete();
    bus.drain_en = 1'b1;
    wait_pulses(0, 3, 30, "ord_pulse_count");
    if (pulses0.size() == 3) begin
      chk("ord_spacing01", 32'(pulses0[1] - pulses0[0]), 32'h3);
      chk("ord_spacing12", 32'(pulses0[2] - pulses0[1]), 32'h3);
    end
    chk("ord_level0", 32'(bus.level), 32'h0);
    chk("ord_empty", 32'(bus.empty), 32'h1);
    tick();
    tick();
    tick();
    bus.drain_en = 1'b0;

    // Window gating
    for (int i = 1; i <= 5; i++) wr(0, 24'h0A0000 + 24'(i), 1'b1);
    chk("win_level5", 32'(bus.level), 32'h5);
    pulses0.delete();
    bus.drain_en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus.drain_en = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("win_two_issues", 32'(pulses0.size()), 32'h2);
    chk("win_level3", 32'(bus.level), 32'h3);
    bus.drain_en = 1'b1;
    wait_pulses(0, 5, 30, "win_remaining");
    chk("win_level0", 32'(bus.level), 32'h0);
    tick();
    tick();
    tick();
    bus.drain_en = 1'b0;

    // Overflow
    for (int i = 0; i < 16; i++) wr(0, 24'h100000 + 24'(i), 1'b1);
    wr(0, 24'hEEEEEE, 1'b0);
    chk("ovf_full", 32'(bus.full), 32'h1);
    chk("ovf_level16", 32'(bus.level), 32'h10);
    chk("ovf_set", 32'(bus.overflow), 32'h1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(bus.overflow), 32'h0);
    bus.ovf_clr = 1'b1;
    wr(0, 24'hEEEEE1, 1'b0);
    bus.ovf_clr = 1'b0;
    chk("ovf_set_wins", 32'(bus.overflow), 32'h1);
    chk("ovf_level_kept", 32'(bus.level), 32'h10);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("ovf_cleared2", 32'(bus.overflow), 32'h0);
    pulses0.delete();
    bus.drain_en = 1'b1;
    wait_pulses(0, 16, 80, "ovf_drain16");
    for (int i = 0; i < 6; i++) tick();
    chk("ovf_no_17th", 32'(pulses0.size()), 32'h10);
    chk("ovf_drained_level", 32'(bus.level), 32'h0);
    bus.drain_en = 1'b0;

    // Full with simultaneous issue (ISSUE_GAP=0)
    for (int i = 0; i < 16; i++) wr(1, 24'h200000 + 24'(i), 1'b1);
    chk("fsi_full", 32'(bus0.full), 32'h1);
    pulses1.delete();
    bus0.drain_en = 1'b1;
    wr(1, 24'hABCDEF, 1'b1);
    chk("fsi_level16", 32'(bus0.level), 32'h10);
    chk("fsi_no_overflow", 32'(bus0.overflow), 32'h0);
    wait_pulses(1, 17, 40, "fsi_pulse_count");
    if (pulses1.size() == 17) begin
      chk("fsi_back_to_back", 32'(pulses1[16] - pulses1[0]), 32'h10);
    end
    chk("fsi_level0", 32'(bus0.level), 32'h0);
    bus0.drain_en = 1'b0;

    // Reset mid-drain
    for (int i = 0; i < 8; i++) wr(0, 24'h300000 + 24'(i), 1'b1);
    pulses0.delete();
    bus.drain_en = 1'b1;
    wait_pulses(0, 2, 20, "mid_two_issued");
    chk("mid_level6", 32'(bus.level), 32'h6);
    rst = 1'b1;
    exp0.delete();
    tick();
    rst = 1'b0;
    chk("mid_rst_out_start", 32'(bus.out_start), 32'h0);
    chk("mid_rst_out_cmd", 32'(bus.out_cmd), 32'h0);
    chk("mid_rst_level", 32'(bus.level), 32'h0);
    chk("mid_rst_empty", 32'(bus.empty), 32'h1);
    chk("mid_rst_full", 32'(bus.full), 32'h0);
    chk("mid_rst_overflow", 32'(bus.overflow), 32'h0);
    chk("mid_rst_irq", 32'(bus.irq_drained), 32'h0);
    for (int i = 0; i < 20; i++) tick();
    chk("mid_no_more_issue", 32'(pulses0.size()), 32'h2);
    chk("mid_level_after", 32'(bus.level), 32'h0);
    bus.drain_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
